// File: rtl/si5340_cfg_sequencer.sv
// Walks a ROM of {page, reg, data} words and emits Si5340 register writes,
// inserting page-select writes only when the page changes.
module si5340_cfg_sequencer #(
  parameter int WORD_NUMBER  = 8,
  parameter int MEM_WIDTH    = 24,
  parameter int DELAY_INDEX  = 2,
  parameter int DELAY_CYCLES = 16,
  localparam int AW = (WORD_NUMBER > 1) ? $clog2(WORD_NUMBER) : 1
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 start_i,
  output logic [AW-1:0]        rom_addr_o,
  input  logic [MEM_WIDTH-1:0] rom_data_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [7:0]           cmd_reg_o,
  output logic [7:0]           cmd_data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, PAGE_CMD, REG_CMD, DELAY, DONE
  } state_t;

  state_t               state;
  logic [AW-1:0]        index;
  logic [MEM_WIDTH-1:0] entry;
  logic [7:0]           cur_page;
  logic                 page_valid;
  logic [DW-1:0]        dcnt;

  logic reg_accept;
  logic at_delay;
  logic at_last;
  logic delay_end;
  logic step;

  assign reg_accept = (state == REG_CMD) && cmd_valid_o && cmd_ready_i;
  assign at_delay   = (32'(index) == DELAY_INDEX);
  assign at_last    = (32'(index) == WORD_NUMBER - 1);
  assign delay_end  = (state == DELAY) && (32'(dcnt) == DELAY_CYCLES - 1);
  // step: move on to the next ROM entry or finish the pass
  assign step       = (reg_accept && !at_delay) || delay_end;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      index       <= '0;
      entry       <= '0;
      cur_page    <= '0;
      page_valid  <= 1'b0;
      dcnt        <= '0;
      cmd_valid_o <= 1'b0;
      cmd_reg_o   <= '0;
      cmd_data_o  <= '0;
      rom_addr_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= FETCH;
            index      <= '0;
            rom_addr_o <= '0;
            busy_o     <= 1'b1;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          entry       <= rom_data_i;
          cmd_valid_o <= 1'b1;
          if (!page_valid || (rom_data_i[23:16] != cur_page)) begin
            cmd_reg_o  <= 8'h01;
            cmd_data_o <= rom_data_i[23:16];
            state      <= PAGE_CMD;
          end else begin
            cmd_reg_o  <= rom_data_i[15:8];
            cmd_data_o <= rom_data_i[7:0];
            state      <= REG_CMD;
          end
        end
        PAGE_CMD: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            cur_page    <= entry[23:16];
            page_valid  <= 1'b1;
            state       <= REG_CMD;
          end
        end
        REG_CMD: begin
          // arriving from PAGE_CMD, valid is low for one cycle before the reg write
          if (!cmd_valid_o) begin
            cmd_valid_o <= 1'b1;
            cmd_reg_o   <= entry[15:8];
            cmd_data_o  <= entry[7:0];
          end else if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            if (entry[15:8] == 8'h01) begin
              cur_page   <= entry[7:0];
              page_valid <= 1'b1;
            end
            if (at_delay) begin
              state <= DELAY;
              dcnt  <= '0;
            end
          end
        end
        DELAY: begin
          if (!delay_end) dcnt <= dcnt + DW'(1);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (step) begin
        if (at_last) begin
          state      <= DONE;
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
          page_valid <= 1'b0;
        end else begin
          index      <= index + AW'(1);
          rom_addr_o <= index + AW'(1);
          state      <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// Scoreboard bench: expected register writes are queued per pass and popped as the DUT hands them off.
module tb_si5340_cfg_sequencer;
  localparam int WN = 2;
  localparam int DI = 0;
  localparam int DC = 16;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        start = 1'b0;
  logic        cmd_ready = 1'b0;
  logic [0:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic        cmd_valid;
  logic [7:0]  cmd_reg;
  logic [7:0]  cmd_data;
  logic        busy;
  logic        done;

  logic [23:0] rom [WN];

  si5340_cfg_sequencer #(
    .WORD_NUMBER(WN), .MEM_WIDTH(24), .DELAY_INDEX(DI), .DELAY_CYCLES(DC)
  ) dut (
    .clk_i(clk), .arstn_i(arstn), .start_i(start),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_reg_o(cmd_reg), .cmd_data_o(cmd_data),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  int done_cnt = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int last_gap = 0;
  logic prev_vld = 1'b0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_cmd = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (done) done_cnt++;
    if (cmd_valid && !prev_vld) last_gap = cyc - last_acc_cyc;
    if (prev_stall) begin
      check_val("hold_vld", 32'(cmd_valid), 32'd1);
      check_val("hold_cmd", 32'({cmd_reg, cmd_data}), 32'(prev_cmd));
    end
    if (cmd_valid && cmd_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
      check_val("cmd", 32'({cmd_reg, cmd_data}), 32'(e));
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    prev_vld   = cmd_valid;
    prev_stall = cmd_valid && !cmd_ready && arstn;
    prev_cmd   = {cmd_reg, cmd_data};
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_vld"},  32'(cmd_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_addr"}, 32'(rom_addr), 32'd0);
    check_val({tag, "_cmd"},  32'({cmd_reg, cmd_data}), 32'd0);
  endtask

  task automatic run_pass(input logic [23:0] a, input logic [23:0] b,
                          input bit lat, input bit extra, input int stall);
    rom[0] = a;
    rom[1] = b;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1; cmd_ready = (stall == 0);
    @(posedge clk); #1 start = 1'b0;
    check_val("busy_start", 32'(busy), 32'd1);
    if (lat) begin
      @(negedge clk); check_val("lat_fetch", 32'(cmd_valid), 32'd0);
      @(negedge clk); check_val("lat_decode", 32'(cmd_valid), 32'd0);
      @(negedge clk); check_val("lat_first", 32'(cmd_valid), 32'd1);
    end
    if (stall > 0) begin
      for (int i = 0; i < 20 && !cmd_valid; i++) @(negedge clk);
      check_val("stall_vld", 32'(cmd_valid), 32'd1);
      repeat (stall) @(posedge clk);
      #1 cmd_ready = 1'b1;
    end
    if (extra) begin
      repeat (6) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge clk);
    check_val("done_seen", 32'(done_cnt), 32'd1);
    repeat (30) @(negedge clk);
    check_val("done_once", 32'(done_cnt), 32'd1);
    check_val("busy_end", 32'(busy), 32'd0);
    check_val("q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    rom[0] = '0;
    rom[1] = '0;
    #12;
    check_reset_outputs("rst0");
    @(negedge clk); arstn = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("idle0");

    // same-page pass: single page write, delay after entry 0
    exp_q.push_back(16'h010B); exp_q.push_back(16'h24C0); exp_q.push_back(16'h2500);
    run_pass(24'h0B24C0, 24'h0B2500, 1'b1, 1'b0, 0);
    check_val("delay_gap_ge16", 32'(last_gap >= DC), 32'd1);

    // page change between entries, with an extra start while busy
    exp_q.push_back(16'h0100); exp_q.push_back(16'h1234);
    exp_q.push_back(16'h0101); exp_q.push_back(16'h2056);
    run_pass(24'h001234, 24'h012056, 1'b0, 1'b1, 0);

    // direct page-register write suppresses the next page write
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0102); exp_q.push_back(16'h03FF);
    run_pass(24'h000102, 24'h0203FF, 1'b0, 1'b0, 0);

    // backpressure on the first command for 10 cycles
    exp_q.push_back(16'h010B); exp_q.push_back(16'h24C0); exp_q.push_back(16'h2500);
    run_pass(24'h0B24C0, 24'h0B2500, 1'b0, 1'b0, 10);

    // reset during the post-entry-0 delay aborts the pass
    base = acc_cnt;
    rom[0] = 24'h0B24C0;
    rom[1] = 24'h0B2500;
    exp_q.push_back(16'h010B); exp_q.push_back(16'h24C0);
    @(posedge clk); #1 start = 1'b1; cmd_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 50 && acc_cnt < base + 2; i++) @(negedge clk);
    check_val("pre_rst_acc", 32'(acc_cnt - base), 32'd2);
    repeat (4) @(posedge clk);
    #1 arstn = 1'b0;
    #2 check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    repeat (40) @(negedge clk);
    check_val("no_cmd_after_rst", 32'(acc_cnt - base), 32'd2);
    check_reset_outputs("idle_after_rst");

    exp_q.push_back(16'h010B); exp_q.push_back(16'h24C0); exp_q.push_back(16'h2500);
    run_pass(24'h0B24C0, 24'h0B2500, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
